// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets, control/status bit positions and the status word packer.
package bus_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam logic [23:0] REG_TXDATA = 24'd0;
  localparam logic [23:0] REG_STATUS = 24'd1;

  localparam int CTRL_WE = 0;
  localparam int CTRL_RE = 1;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_CLR   = STAT_OVF;

  // Count occupies bits [31:4]; callers zero-extend their FIFO count.
  function automatic logic [31:0] pack_status(input logic [27:0] count,
                                              input logic ovf,
                                              input logic busy,
                                              input logic empty,
                                              input logic full);
    return {count, ovf, busy, empty, full};
  endfunction

endpackage

// File: rtl/bus_uart_tx_sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count; push when full and
// pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array is deliberately left without reset (pointers and
  // count define validity), and sequential state is always assigned with <=.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA feed a byte FIFO that a
// serialiser drains; STATUS is readable and its overflow flag is write-1-to-clear.
module bus_uart_tx
  import bus_uart_tx_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR    = 24'hFFFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [23:0] address_bus,
  input  logic [31:0] wdata_bus,
  input  logic [1:0]  control_bus,
  output logic [31:0] rdata_bus,
  output logic        tx,
  output logic        tx_idle_irq
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e        state;
  logic [BW-1:0]    baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             overflow;

  logic             we, re, sel_data, sel_stat;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] fifo_count;
  logic             baud_end, busy;

  assign we       = control_bus[CTRL_WE];
  assign re       = control_bus[CTRL_RE];
  assign sel_data = (address_bus == BASE_ADDR + REG_TXDATA);
  assign sel_stat = (address_bus == BASE_ADDR + REG_STATUS);

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign busy      = (state != ST_IDLE);
  assign fifo_push = we && sel_data;
  // Pop only when a new frame starts: from idle, or back-to-back at stop end.
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .nreset(nreset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wdata_bus[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overflow <= 1'b0;
    end else if (we && sel_data && fifo_full) begin
      overflow <= 1'b1;
    end else if (we && sel_stat && wdata_bus[STAT_CLR]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (fifo_pop) begin
            shift    <= fifo_dout;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (fifo_pop) begin
              shift <= fifo_dout;
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_idle_irq = (state == ST_IDLE) && fifo_empty;
  assign rdata_bus   = (re && sel_stat)
                     ? pack_status(28'(fifo_count), overflow, busy, fifo_empty, fifo_full)
                     : 32'h0;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: a frame-timeline model (byte queue plus
// cycle index within the current frame) checked every cycle, plus literal checks.
module tb_bus_uart_tx;

  localparam logic [23:0] BASE  = 24'hFFFF00;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [23:0] address_bus = '0;
  logic [31:0] wdata_bus = '0;
  logic [1:0]  control_bus = 2'b00;
  logic [31:0] rdata_bus;
  logic        tx;
  logic        tx_idle_irq;

  bus_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .address_bus(address_bus),
    .wdata_bus  (wdata_bus),
    .control_bus(control_bus),
    .rdata_bus  (rdata_bus),
    .tx         (tx),
    .tx_idle_irq(tx_idle_irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending bytes, overflow flag, and position m_t within the frame in flight.
  logic [7:0] m_q[$];
  logic       m_ovf    = 1'b0;
  bit         m_active = 1'b0;
  logic [7:0] m_byte   = 8'h00;
  int         m_t      = 0;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_t      = 0;
    end else begin
      int pre_n;
      bit take;
      pre_n = m_q.size();
      take  = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == 10*CPB) begin
          if (pre_n > 0) take = 1'b1;
          else m_active = 1'b0;
        end
      end else if (pre_n > 0) begin
        take = 1'b1;
      end
      if (take) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (control_bus[0] && address_bus == BASE) begin
        if (pre_n == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(wdata_bus[7:0]);
      end
      if (control_bus[0] && address_bus == BASE + 24'd1 && wdata_bus[3]) m_ovf = 1'b0;
    end
  end

  function automatic logic exp_tx();
    if (!m_active)     return 1'b1;
    if (m_t < CPB)     return 1'b0;
    if (m_t < 9*CPB)   return m_byte[m_t/CPB - 1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    int n = m_q.size();
    logic [31:0] s;
    s = 32'(n) << 4;
    if (m_ovf)      s = s | 32'h8;
    if (m_active)   s = s | 32'h4;
    if (n == 0)     s = s | 32'h2;
    if (n == DEPTH) s = s | 32'h1;
    return s;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (control_bus[1] && address_bus == BASE + 24'd1) return exp_status();
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    check("tx", {31'b0, tx}, {31'b0, exp_tx()});
    check("irq", {31'b0, tx_idle_irq}, {31'b0, !m_active && m_q.size() == 0});
    check("rdata", rdata_bus, exp_rdata());
  end

  task automatic drive(input logic [23:0] a, input logic [31:0] d, input logic [1:0] c);
    @(posedge clk);
    #2;
    address_bus = a;
    wdata_bus   = d;
    control_bus = c;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    drive(BASE + 24'd1, 32'h0, 2'b10);
    #1;
    check(name, rdata_bus, exp);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (tx_idle_irq !== 1'b1 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, {31'b0, tx_idle_irq}, 32'h1);
  endtask

  logic [9:0] a5_frame = 10'b1_1010_0101_0;

  initial begin
    // Reset, then abort a frame with an asynchronous reset.
    repeat (3) @(posedge clk);
    #2 nreset = 1'b1;
    read_status("status_after_reset", 32'h0000_0002);
    drive(BASE, 32'h3C, 2'b01);
    drive(24'h0, 32'h0, 2'b00);
    repeat (40) @(posedge clk);
    #3 nreset = 1'b0;
    #1;
    check("reset_tx_immediate", {31'b0, tx}, 32'h1);
    check("reset_irq", {31'b0, tx_idle_irq}, 32'h1);
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    read_status("status_after_mid_reset", 32'h0000_0002);

    // Single byte 0xA5: latency and bit pattern.
    drive(BASE, 32'hFFFF_FFA5, 2'b01);
    drive(24'h0, 32'h0, 2'b00);
    check("a5_before_start", {31'b0, tx}, 32'h1);
    @(posedge clk);
    #2;
    check("a5_bit0", {31'b0, tx}, {31'b0, a5_frame[0]});
    for (int i = 1; i < 10; i++) begin
      repeat (CPB) @(posedge clk);
      #2;
      check($sformatf("a5_bit%0d", i), {31'b0, tx}, {31'b0, a5_frame[i]});
    end
    repeat (CPB) @(posedge clk);
    #2;
    check("a5_irq_after_160", {31'b0, tx_idle_irq}, 32'h1);

    // Three bytes back-to-back: contiguous frames.
    begin
      int cnt;
      drive(BASE, $urandom(), 2'b01);
      drive(BASE, $urandom(), 2'b01);
      drive(BASE, $urandom(), 2'b01);
      drive(24'h0, 32'h0, 2'b00);
      cnt = 1;  // one edge of the first frame has already passed here
      while (tx_idle_irq !== 1'b1 && cnt < 1000) begin
        @(posedge clk);
        #2;
        cnt++;
      end
      check("three_frames_len", 32'(cnt), 32'd480);
    end

    // Ten bytes during the first frame: overflow, clear, passive loads.
    for (int i = 0; i < 10; i++) drive(BASE, $urandom(), 2'b01);
    read_status("status_overflow", 32'h0000_008D);
    drive(BASE + 24'd1, 32'h8, 2'b01);
    read_status("status_ovf_cleared", 32'h0000_0085);
    drive(BASE, 32'h0, 2'b10);
    #1;
    check("load_txdata_zero", rdata_bus, 32'h0);
    drive(BASE + 24'd2, 32'h0, 2'b10);
    #1;
    check("load_base2_zero", rdata_bus, 32'h0);
    read_status("status_unchanged", 32'h0000_0085);
    drive(24'h0, 32'h0, 2'b00);
    wait_idle(2000, "drain_after_overflow");

    // Read-and-clear in one cycle returns the pre-edge status.
    for (int i = 0; i < 10; i++) drive(BASE, $urandom(), 2'b01);
    drive(24'h0, 32'h0, 2'b00);
    wait_idle(2000, "drain_before_rw");
    drive(BASE + 24'd1, 32'h8, 2'b11);
    #1;
    check("rw_pre_edge", rdata_bus, 32'h0000_000A);
    read_status("rw_post_edge", 32'h0000_0002);

    // Randomized traffic: a dense phase that overflows, then a sparse one.
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 2500; c++) begin
        int r;
        r = $urandom_range(0, (ph == 0) ? 15 : 255);
        case (r)
          0, 1:    drive(BASE, $urandom(), 2'b01);
          2:       drive(BASE + 24'd1, $urandom(), 2'b01);
          3, 4:    drive(BASE + 24'd1, $urandom(), 2'b10);
          5:       drive(BASE, $urandom(), 2'b10);
          6:       drive(BASE + 24'd1, $urandom(), 2'b11);
          7:       drive(24'($urandom()), $urandom(), 2'($urandom()));
          default: drive(24'h0, 32'h0, 2'b00);
        endcase
        if (ph == 1 && c == 1200) begin
          @(posedge clk);
          #3 nreset = 1'b0;
          @(posedge clk);
          #2 nreset = 1'b1;
        end
      end
    end
    drive(24'h0, 32'h0, 2'b00);
    wait_idle(3000, "final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
